mcp300x_responder: RTL and testbench
====================================

# mcp300x_responder

Synthesizable SPI responder that emulates an MCP3008-style 10-bit ADC at the far end of the joystick SPI link. It decodes the start/SGL/channel command clocked in by the SPI master and shifts back a 10-bit value taken from a per-channel input bus. It is used for on-board loopback testing of the joystick read path when no ADC chip is fitted. All SPI inputs are oversampled in the system clock domain.

## Interface
- Parameters: none.
- `clk_27MHz`  in  1  system clock.
- `reset_btn`  in  1  synchronous, active-high reset.
- `spi_CLK`  in  1  SCLK from the master, asynchronous, SPI mode 0 (idle low).
- `mcp_CS`  in  1  chip select, active low, asynchronous.
- `spi_MOSI`  in  1  command data from the master, asynchronous.
- `ch_values`  in  80  channel n value at bits [10n+9:10n], n = 0..7.
- `spi_MISO`  out  1  result data; 0 whenever `miso_oe` = 0.
- `miso_oe`  out  1  MISO drive enable (tri-state control at top level).
- `conv_valid`  out  1  one-cycle pulse when B0 is driven.
- `conv_channel`  out  3  D2..D0 of the last accepted command.
- `conv_sgl`  out  1  SGL/DIFF bit of the last accepted command.
- `frame_error`  out  1  one-cycle pulse when CS rises before B0 is driven.

## Operation
- `spi_CLK`, `mcp_CS` and `spi_MOSI` each pass through a 2-FF synchronizer plus one history register. Rise and fall are detected as one-cycle strobes. Reset preloads: CS = 1, CLK = 0, MOSI = 0.
- MOSI is sampled from the synchronized value in the same cycle as the rise strobe.
- States: IDLE, WAIT_START, CMD, ACQ, MSB, LSB, TAIL.
- IDLE: `miso_oe` = 0. On a synchronized CS fall, go to WAIT_START.
- WAIT_START: on each rise, if MOSI = 1 go to CMD with bit count 0. Rises with MOSI = 0 are ignored, so leading zeros are allowed.
- CMD: the next 4 rises shift in SGL, D2, D1, D0, MSB first.
  - On the D0 rise, the 10-bit word from `ch_values[channel]` is latched into the shift register.
  - `conv_channel` and `conv_sgl` are updated on the same rise.
  - Go to ACQ. Later changes to `ch_values` do not affect the frame.
- ACQ: falls are counted from the D0 rise.
  - Fall 1: no action.
  - Fall 2: drive null bit 0 and set `miso_oe` = 1, then go to MSB.
- MSB: falls 3..12 drive B9..B0. `conv_valid` pulses in the cycle B0 is driven. Then go to LSB.
- LSB: falls 13..21 drive B1..B9 (LSB-first repeat). Then go to TAIL.
- TAIL: every further fall drives 0 while `miso_oe` stays 1.
- CS rise in any state except IDLE:
  - go to IDLE next cycle and drop `miso_oe` and `spi_MISO` to 0;
  - if the state is WAIT_START, CMD, ACQ or MSB before B0 was driven, pulse `frame_error`.
- CS rise in the same cycle as a CLK edge strobe: CS wins and the edge is ignored.
- SGL/DIFF only sets `conv_sgl`. The returned value is always `ch_values[channel]`.

## Timing
- Reset: all outputs 0, state IDLE. `conv_channel` = 0, `conv_sgl` = 0.
- Reset asserted mid-frame aborts the frame with no `frame_error`.
- CS held low across reset release produces a synchronized CS fall and starts a new frame.
- Latency from a physical SCLK edge to a decoded action or MISO update is 3–4 `clk_27MHz` cycles (≤ 150 ns).
- SCLK high and low phases must each be ≥ 4 system cycles (SCLK ≤ 3 MHz). The nominal 2 MHz link meets this.
- `conv_valid` and `frame_error` are mutually exclusive within one frame.
- Counters: 4-bit fall counter and 3-bit command counter. No wrap is possible before TAIL, and TAIL holds.

## Test plan
- Standard frame:
  - Stimulus: `ch_values` ch0 = 0x2A5; master sends 0x01, 0x80, 0x00 at 2 MHz.
  - Response: master reads 0x00, 0x02, 0xA5; one `conv_valid`; `conv_channel` = 0; `conv_sgl` = 1.
- Channel decode:
  - ch1 = 0x3FF with command 0x90 → master reads bytes 2–3 = 0x03, 0xFF.
  - ch7 = 0x001 with command 0xF0 → master reads 0x00, 0x01; `conv_channel` = 7.
- Extended frame:
  - Stimulus: 4 bytes 0x01, 0x80, 0x00, 0x00 with ch0 = 0x2A5.
  - Response: byte 4 = 0x4A (B1..B8 LSB-first); `miso_oe` stays 1 until CS rises.
- Abort:
  - Stimulus: CS rises after 10 SCLKs.
  - Response: one `frame_error`, no `conv_valid`, `miso_oe` = 0 within 4 cycles; the next standard frame reads correctly.
- Value latch:
  - Stimulus: ch0 changes from 0x2A5 to 0x155 immediately after the D0 rise.
  - Response: master still reads 0x02, 0xA5.
- Reset mid-frame:
  - Stimulus: assert `reset_btn` during MSB.
  - Response: all outputs 0, no error pulse; the following frame returns correct data.

Source files
------------

// File: rtl/mcp300x_responder_if.sv
// SPI pin bundle between a joystick SPI master and the
// emulated MCP3008 responder.
interface mcp300x_responder_if;
  logic spi_CLK;
  logic mcp_CS;
  logic spi_MOSI;
  logic spi_MISO;
  logic miso_oe;

  modport master (
    output spi_CLK,
    output mcp_CS,
    output spi_MOSI,
    input  spi_MISO,
    input  miso_oe
  );

  modport slave (
    input  spi_CLK,
    input  mcp_CS,
    input  spi_MOSI,
    output spi_MISO,
    output miso_oe
  );
endinterface

// File: rtl/mcp300x_responder.sv
// MCP3008-style SPI responder: decodes start/SGL/channel and
// returns the selected 10-bit channel value, MSB then LSB first.
module mcp300x_responder (
  input  logic                clk_27MHz,
  input  logic                reset_btn,
  mcp300x_responder_if.slave  spi,
  input  logic [79:0]         ch_values,
  output logic                conv_valid,
  output logic [2:0]          conv_channel,
  output logic                conv_sgl,
  output logic                frame_error
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    ACQ,
    MSB,
    LSB,
    TAIL
  } state_t;

  // bit0 = first sync FF, bit1 = second, bit2 = history
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_s;

  state_t     state_q;
  logic [2:0] cmd_q;
  logic [2:0] ccnt_q;
  logic [3:0] fcnt_q;
  logic [9:0] sh_q;
  logic       miso_q;
  logic       oe_q;
  logic       valid_q;
  logic       ferr_q;
  logic [2:0] chan_q;
  logic       sgl_q;

  logic [2:0] ch_sel_d;
  logic [9:0] ch_word_d;

  // Oversample the asynchronous SPI pins; CS idles high.
  always_ff @(posedge clk_27MHz) begin
    if (reset_btn) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.spi_CLK};
      cs_q   <= {cs_q[1:0], spi.mcp_CS};
      mosi_q <= {mosi_q[0], spi.spi_MOSI};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

  // Channel picked by D2..D0, D0 arriving on this rise.
  assign ch_sel_d = {cmd_q[1:0], mosi_s};

  // Mux the selected channel word out of the flat bus.
  always_comb begin
    ch_word_d = '0;
    for (int n = 0; n < 8; n++) begin
      if (ch_sel_d == 3'(n)) begin
        ch_word_d = ch_values[10*n +: 10];
      end
    end
  end

  // Frame FSM with registered MISO, enable and status pulses.
  always_ff @(posedge clk_27MHz) begin
    if (reset_btn) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      ccnt_q  <= '0;
      fcnt_q  <= '0;
      sh_q    <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      chan_q  <= '0;
      sgl_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (cs_rise && state_q != IDLE) begin
        state_q <= IDLE;
        miso_q  <= 1'b0;
        oe_q    <= 1'b0;
        ferr_q  <= state_q inside
                   {WAIT_START, CMD, ACQ, MSB};
      end else begin
        unique case (state_q)
          IDLE: begin
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
            if (cs_fall) begin
              state_q <= WAIT_START;
            end
          end
          WAIT_START: begin
            if (sclk_rise && mosi_s) begin
              state_q <= CMD;
              ccnt_q  <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_q  <= {cmd_q[1:0], mosi_s};
              ccnt_q <= ccnt_q + 3'd1;
              if (ccnt_q == 3'd3) begin
                sgl_q   <= cmd_q[2];
                chan_q  <= ch_sel_d;
                sh_q    <= ch_word_d;
                fcnt_q  <= '0;
                state_q <= ACQ;
              end
            end
          end
          ACQ: begin
            if (sclk_fall) begin
              if (fcnt_q == 4'd1) begin
                miso_q  <= 1'b0;
                oe_q    <= 1'b1;
                fcnt_q  <= 4'd9;
                state_q <= MSB;
              end else begin
                fcnt_q <= fcnt_q + 4'd1;
              end
            end
          end
          MSB: begin
            if (sclk_fall) begin
              miso_q <= sh_q[fcnt_q];
              if (fcnt_q == 4'd0) begin
                valid_q <= 1'b1;
                fcnt_q  <= 4'd1;
                state_q <= LSB;
              end else begin
                fcnt_q <= fcnt_q - 4'd1;
              end
            end
          end
          LSB: begin
            if (sclk_fall) begin
              miso_q <= sh_q[fcnt_q];
              if (fcnt_q == 4'd9) begin
                state_q <= TAIL;
              end else begin
                fcnt_q <= fcnt_q + 4'd1;
              end
            end
          end
          TAIL: begin
            if (sclk_fall) begin
              miso_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi.spi_MISO = miso_q;
  assign spi.miso_oe  = oe_q;
  assign conv_valid   = valid_q;
  assign conv_channel = chan_q;
  assign conv_sgl     = sgl_q;
  assign frame_error  = ferr_q;

endmodule

// File: tb/tb_mcp300x_responder.sv
// Bench for mcp300x_responder: bit-level SPI master plus
// a frame-level reference model of the returned bitstream.
`timescale 1ns/1ps
module tb_mcp300x_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] ch_values;
  logic        conv_valid;
  logic [2:0]  conv_channel;
  logic        conv_sgl;
  logic        frame_error;

  logic [9:0]  chv [8];

  int errors = 0;
  int checks = 0;
  int n_cv = 0;
  int n_fe = 0;
  int n_bad = 0;

  logic [63:0] rx_w;
  logic        oe_before;
  int          drop_cyc;
  logic [7:0]  rst_snap;

  mcp300x_responder_if spi ();

  mcp300x_responder dut (
    .clk_27MHz    (clk),
    .reset_btn    (rst),
    .spi          (spi),
    .ch_values    (ch_values),
    .conv_valid   (conv_valid),
    .conv_channel (conv_channel),
    .conv_sgl     (conv_sgl),
    .frame_error  (frame_error)
  );

  always #18.5 clk = ~clk;

  always_comb begin
    ch_values = '0;
    for (int n = 0; n < 8; n++) ch_values[10*n +: 10] = chv[n];
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (conv_valid === 1'b1) n_cv++;
      if (frame_error === 1'b1) n_fe++;
      if (spi.miso_oe === 1'b0 && spi.spi_MISO !== 1'b0) n_bad++;
    end
  end

  // Command stream: lead zeros, start bit, SGL, D2..D0, zeros.
  function automatic logic [63:0] make_tx(int nbits, int lead,
                                          logic sgl, logic [2:0] ch);
    logic [63:0] t;
    t = '0;
    t[nbits-1-lead] = 1'b1;
    t[nbits-2-lead] = sgl;
    t[nbits-3-lead] = ch[2];
    t[nbits-4-lead] = ch[1];
    t[nbits-5-lead] = ch[0];
    return t;
  endfunction

  // Bit seen by the master on the j-th rise after the D0 rise:
  // null at j=2, B9..B0 at 3..12, B1..B9 at 13..21, else 0.
  function automatic logic [63:0] model_rx(int nbits, int d0,
                                           logic [9:0] v);
    logic [63:0] r;
    int j;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      j = i - d0;
      if (j >= 3 && j <= 12) r[nbits-1-i] = v[12-j];
      else if (j >= 13 && j <= 21) r[nbits-1-i] = v[j-12];
    end
    return r;
  endfunction

  task automatic spi_frame(input int nbits, input logic [63:0] tx,
                           input int stop_after, input int chg_at,
                           input logic [9:0] chg_val,
                           input bit rst_mid);
    int nb;
    nb = (stop_after > 0) ? stop_after : nbits;
    rx_w = '0;
    @(negedge clk);
    spi.mcp_CS = 1'b0;
    spi.spi_MOSI = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      spi.spi_MOSI = tx[nbits-1-i];
      repeat (7) @(negedge clk);
      rx_w[nbits-1-i] = spi.spi_MISO;
      spi.spi_CLK = 1'b1;
      if (i == chg_at) begin
        repeat (5) @(negedge clk);
        chv[0] = chg_val;
        repeat (2) @(negedge clk);
      end else begin
        repeat (7) @(negedge clk);
      end
      spi.spi_CLK = 1'b0;
    end
    repeat (7) @(negedge clk);
    oe_before = spi.miso_oe;
    if (rst_mid) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst_snap = {spi.spi_MISO, spi.miso_oe, conv_valid,
                  conv_channel, conv_sgl, frame_error};
      spi.mcp_CS = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drop_cyc = 0;
    end else begin
      spi.mcp_CS = 1'b1;
      drop_cyc = 99;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (spi.miso_oe === 1'b0) begin
          drop_cyc = k;
          break;
        end
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    spi.mcp_CS = 1'b1;
    spi.spi_CLK = 1'b0;
    spi.spi_MOSI = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi.spi_MISO, spi.miso_oe} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pins got=%b want=00",
               {spi.spi_MISO, spi.miso_oe});
    end
    checks++;
    if ({conv_valid, frame_error} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses got=%b want=00",
               {conv_valid, frame_error});
    end
    checks++;
    if ({conv_channel, conv_sgl} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_conv got=%b want=0000",
               {conv_channel, conv_sgl});
    end
  endtask

  task automatic test_standard();
    int cv0, fe0;
    chv[0] = 10'h2A5;
    cv0 = n_cv;
    fe0 = n_fe;
    spi_frame(24, make_tx(24, 7, 1'b1, 3'd0), 0, -1, '0, 1'b0);
    checks++;
    if (rx_w[23:0] !== 24'h0002A5) begin
      errors++;
      $display("FAIL std_data got=%h want=0002a5", rx_w[23:0]);
    end
    checks++;
    if (n_cv - cv0 != 1 || n_fe - fe0 != 0) begin
      errors++;
      $display("FAIL std_pulses cv=%0d fe=%0d want 1 0",
               n_cv - cv0, n_fe - fe0);
    end
    checks++;
    if (conv_channel !== 3'd0 || conv_sgl !== 1'b1) begin
      errors++;
      $display("FAIL std_cmd ch=%0d sgl=%b want 0 1",
               conv_channel, conv_sgl);
    end
  endtask

  task automatic test_channel();
    chv[1] = 10'h3FF;
    chv[7] = 10'h001;
    spi_frame(24, make_tx(24, 7, 1'b1, 3'd1), 0, -1, '0, 1'b0);
    checks++;
    if (rx_w[15:0] !== 16'h03FF) begin
      errors++;
      $display("FAIL ch1_data got=%h want=03ff", rx_w[15:0]);
    end
    spi_frame(24, make_tx(24, 7, 1'b1, 3'd7), 0, -1, '0, 1'b0);
    checks++;
    if (rx_w[15:0] !== 16'h0001 || conv_channel !== 3'd7) begin
      errors++;
      $display("FAIL ch7 got=%h ch=%0d want=0001 ch=7",
               rx_w[15:0], conv_channel);
    end
  endtask

  task automatic test_extended();
    chv[0] = 10'h2A5;
    spi_frame(32, make_tx(32, 7, 1'b1, 3'd0), 0, -1, '0, 1'b0);
    checks++;
    if (rx_w[31:0] !== 32'h0002A54A) begin
      errors++;
      $display("FAIL ext_data got=%h want=0002a54a", rx_w[31:0]);
    end
    checks++;
    if (oe_before !== 1'b1 || drop_cyc > 4) begin
      errors++;
      $display("FAIL ext_oe before=%b drop=%0d want 1 <=4",
               oe_before, drop_cyc);
    end
  endtask

  task automatic test_abort();
    int cv0, fe0;
    cv0 = n_cv;
    fe0 = n_fe;
    spi_frame(24, make_tx(24, 7, 1'b1, 3'd0), 10, -1, '0, 1'b0);
    checks++;
    if (n_fe - fe0 != 1 || n_cv - cv0 != 0 || drop_cyc > 4) begin
      errors++;
      $display("FAIL abort fe=%0d cv=%0d drop=%0d want 1 0 <=4",
               n_fe - fe0, n_cv - cv0, drop_cyc);
    end
    chv[0] = 10'h2A5;
    cv0 = n_cv;
    spi_frame(24, make_tx(24, 7, 1'b1, 3'd0), 0, -1, '0, 1'b0);
    checks++;
    if (rx_w[23:0] !== 24'h0002A5 || n_cv - cv0 != 1) begin
      errors++;
      $display("FAIL after_abort got=%h cv=%0d want=0002a5 1",
               rx_w[23:0], n_cv - cv0);
    end
  endtask

  task automatic test_value_latch();
    chv[0] = 10'h2A5;
    spi_frame(24, make_tx(24, 7, 1'b1, 3'd0), 0, 11, 10'h155, 1'b0);
    checks++;
    if (rx_w[15:0] !== 16'h02A5) begin
      errors++;
      $display("FAIL latch got=%h want=02a5", rx_w[15:0]);
    end
  endtask

  task automatic test_reset_midframe();
    int cv0, fe0;
    logic [63:0] exp;
    chv[5] = 10'($urandom);
    cv0 = n_cv;
    fe0 = n_fe;
    spi_frame(24, make_tx(24, 7, 1'b0, 3'd5), 16, -1, '0, 1'b1);
    checks++;
    if (rst_snap !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_outs got=%b want=00000000", rst_snap);
    end
    checks++;
    if (n_fe - fe0 != 0 || n_cv - cv0 != 0) begin
      errors++;
      $display("FAIL rst_mid_pulses fe=%0d cv=%0d want 0 0",
               n_fe - fe0, n_cv - cv0);
    end
    exp = model_rx(24, 11, chv[5]);
    spi_frame(24, make_tx(24, 7, 1'b0, 3'd5), 0, -1, '0, 1'b0);
    checks++;
    if (rx_w !== exp || conv_channel !== 3'd5) begin
      errors++;
      $display("FAIL rst_mid_next got=%h ch=%0d want=%h ch=5",
               rx_w, conv_channel, exp);
    end
  endtask

  task automatic test_random();
    int cv0, fe0, lead, nbits, d0;
    logic sgl;
    logic [2:0] ch;
    logic [63:0] exp;
    for (int t = 0; t < 16; t++) begin
      for (int n = 0; n < 8; n++) chv[n] = 10'($urandom);
      sgl = 1'($urandom);
      ch = 3'($urandom);
      lead = int'($urandom_range(0, 10));
      nbits = lead + 5 + 21 + int'($urandom_range(0, 6));
      d0 = lead + 4;
      exp = model_rx(nbits, d0, chv[ch]);
      cv0 = n_cv;
      fe0 = n_fe;
      spi_frame(nbits, make_tx(nbits, lead, sgl, ch), 0, -1,
                '0, 1'b0);
      checks++;
      if (rx_w !== exp) begin
        errors++;
        $display("FAIL rnd%0d_data got=%h want=%h", t, rx_w, exp);
      end
      checks++;
      if (n_cv - cv0 != 1 || n_fe - fe0 != 0 ||
          conv_channel !== ch || conv_sgl !== sgl) begin
        errors++;
        $display("FAIL rnd%0d_status cv=%0d fe=%0d ch=%0d sgl=%b want 1 0 %0d %b",
                 t, n_cv - cv0, n_fe - fe0, conv_channel, conv_sgl,
                 ch, sgl);
      end
    end
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL miso_idle got=%0d want=0 cycles", n_bad);
    end
  endtask

  initial begin
    for (int n = 0; n < 8; n++) chv[n] = 10'($urandom);
    test_reset();
    test_standard();
    test_channel();
    test_extended();
    test_abort();
    test_value_latch();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
